// File: rtl/gpio_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of the GPIO slave.
package gpio_arb_pkg;

    // Arbiter FSM encoding; 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

    // Master identifiers, also the encoding of the round-robin pointer.
    localparam logic Master0 = 1'b0;
    localparam logic Master1 = 1'b1;

    // Grant state that serves the given master.
    function automatic arb_state_e grant_state(input logic id);
        return (id == Master1) ? StGrant1 : StGrant0;
    endfunction

endpackage

// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter letting two Wishbone masters share one GPIO slave,
// with a per-transfer ack timeout.
module gpio_wb_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    // Counter value at which the final permitted grant cycle is running.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic        prio_q, prio_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        granted;
    logic        gnt_id;
    logic        gnt_stb;
    logic        gnt_we;
    logic [3:0]  gnt_sel;
    logic [31:0] gnt_dat;
    logic        timeout;

    // Select the currently granted master's request signals.
    always_comb begin
        granted = (state_q == StGrant0) || (state_q == StGrant1);
        gnt_id  = (state_q == StGrant1) ? Master1 : Master0;
        gnt_stb = (gnt_id == Master1) ? m1_stb_i : m0_stb_i;
        gnt_we  = (gnt_id == Master1) ? m1_we_i  : m0_we_i;
        gnt_sel = (gnt_id == Master1) ? m1_sel_i : m0_sel_i;
        gnt_dat = (gnt_id == Master1) ? m1_dat_i : m0_dat_i;
        // An abort (stb dropped) wins over the timeout in the same cycle.
        timeout = granted && gnt_stb && !s_ack_i && (cnt_q == TimeoutLast);
    end

    // Next-state logic: arbitration in idle, completion/abort/timeout in grant.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (m0_stb_i && m1_stb_i) begin
                    state_d = grant_state(prio_q);
                end else if (m0_stb_i) begin
                    state_d = StGrant0;
                end else if (m1_stb_i) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (s_ack_i) begin
                    state_d = StIdle;
                    prio_d  = ~gnt_id;
                end else if (!gnt_stb) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d = StIdle;
                    prio_d  = ~gnt_id;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            prio_q  <= Master0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational routing; reset forces the slave side and handshakes low.
    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        if (!wb_rst_i && granted) begin
            s_stb_o  = gnt_stb;
            s_we_o   = gnt_we;
            s_sel_o  = gnt_sel;
            s_dat_o  = gnt_dat;
            m0_ack_o = s_ack_i && (gnt_id == Master0);
            m1_ack_o = s_ack_i && (gnt_id == Master1);
            m0_err_o = timeout && (gnt_id == Master0);
            m1_err_o = timeout && (gnt_id == Master1);
        end
    end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_gpio_wb_arbiter;

    localparam int T = 15;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        mstb [2];
    logic        mwe  [2];
    logic [3:0]  msel [2];
    logic [31:0] mdat [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    // GPIO slave model: {dir, state} register, one-cycle registered ack.
    logic [31:0] gpio_reg = '0;
    logic        ack_q = 1'b0;
    logic        rnd_ack = 1'b0;
    int          slave_mode = 0;  // 0 responsive, 1 never acks, 2 random ack
    logic        mdone [2];

    int pass_cnt = 0;
    int chk_cnt = 0;

    assign s_ack_i = (slave_mode == 0) ? ack_q : (slave_mode == 2) ? rnd_ack : 1'b0;
    assign s_dat_i = gpio_reg;

    gpio_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0_stb_i (mstb[0]),
        .m0_we_i  (mwe[0]),
        .m0_sel_i (msel[0]),
        .m0_dat_i (mdat[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_stb_i (mstb[1]),
        .m1_we_i  (mwe[1]),
        .m1_sel_i (msel[1]),
        .m1_dat_i (mdat[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        ack_q <= s_stb_o && !ack_q;
        if (s_stb_o && s_we_o && s_ack_i) begin
            for (int b = 0; b < 4; b++) begin
                if (s_sel_o[b]) gpio_reg[8*b +: 8] <= s_dat_o[8*b +: 8];
            end
        end
    end

    // Transaction-level reference: who owns the bus and for how many cycles.
    logic busy = 1'b0;
    logic who = 1'b0;
    logic rr = 1'b0;
    int   gcyc = 0;   // 1-based count of grant cycles of the current transfer

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            busy <= 1'b0;
            rr   <= 1'b0;
            gcyc <= 0;
        end else if (!busy) begin
            if (mstb[0] || mstb[1]) begin
                busy <= 1'b1;
                who  <= (mstb[0] && mstb[1]) ? rr : mstb[1];
                gcyc <= 1;
            end
        end else if (s_ack_i) begin
            busy <= 1'b0;
            rr   <= !who;
        end else if (!mstb[who]) begin
            busy <= 1'b0;
        end else if (gcyc == T) begin
            busy <= 1'b0;
            rr   <= !who;
        end else begin
            gcyc <= gcyc + 1;
        end
    end

    logic        e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_sdat;
    logic [1:0]  e_ack, e_err;
    logic [9:0]  e_ctrl, dut_ctrl;

    always_comb begin
        e_stb  = 1'b0;
        e_we   = 1'b0;
        e_sel  = '0;
        e_sdat = '0;
        e_ack  = '0;
        e_err  = '0;
        if (!wb_rst_i && busy) begin
            e_stb       = mstb[who];
            e_we        = mwe[who];
            e_sel       = msel[who];
            e_sdat      = mdat[who];
            e_ack[who]  = s_ack_i;
            e_err[who]  = !s_ack_i && mstb[who] && (gcyc == T);
        end
    end

    assign e_ctrl   = {e_stb, e_we, e_sel, e_err[1], e_ack[1], e_err[0], e_ack[0]};
    assign dut_ctrl = {s_stb_o, s_we_o, s_sel_o, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the reference, mid-cycle.
    always @(negedge wb_clk_i) begin
        chk("cyc_ctrl", 32'(dut_ctrl), 32'(e_ctrl));
        chk("cyc_s_dat", s_dat_o, e_sdat);
        chk("cyc_m0_dat", m0_dat_o, gpio_reg);
        chk("cyc_m1_dat", m1_dat_o, gpio_reg);
        mdone[0] <= m0_ack_o | m0_err_o;
        mdone[1] <= m1_ack_o | m1_err_o;
    end

    task automatic dc();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic look();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        mstb[0]  = 1'b0;
        mstb[1]  = 1'b0;
        dc();
        dc();
        wb_rst_i = 1'b0;
    endtask

    task automatic new_req(input int m);
        mwe[m]  = 1'($urandom);
        msel[m] = 4'($urandom);
        mdat[m] = $urandom;
    endtask

    initial begin
        int k;
        int order [4];
        int n_acks;
        logic ack_seen;

        for (int m = 0; m < 2; m++) begin
            mstb[m] = 1'b0; mwe[m] = 1'b0; msel[m] = '0; mdat[m] = '0; mdone[m] = 1'b0;
        end

        // Single write then read-back through master 0.
        slave_mode = 0;
        do_reset();
        mstb[0] = 1'b1; mwe[0] = 1'b1; msel[0] = 4'hF; mdat[0] = 32'h0003_00A5;
        look(); chk("single_t0_stb", 32'(s_stb_o), 32'd0);
        dc(); look(); chk("single_t1_stb", 32'(s_stb_o), 32'd1);
        chk("single_t1_dat", s_dat_o, 32'h0003_00A5);
        chk("single_t1_ack", 32'(m0_ack_o), 32'd0);
        dc(); look(); chk("single_t2_ack", 32'(m0_ack_o), 32'd1);
        dc(); mstb[0] = 1'b0;
        look(); chk("single_t3_stb", 32'(s_stb_o), 32'd0);
        chk("gpio_dir", 32'(gpio_reg[31:16]), 32'h0003);
        chk("gpio_state", 32'(gpio_reg[15:0]), 32'h00A5);
        dc(); mstb[0] = 1'b1; mwe[0] = 1'b0;
        look(); dc(); look(); dc(); look();
        chk("readback_ack", 32'(m0_ack_o), 32'd1);
        chk("readback_dat", m0_dat_o, 32'h0003_00A5);
        dc(); mstb[0] = 1'b0;

        // Contention right after reset: master 0 first, master 1 at t+4.
        do_reset();
        mstb[0] = 1'b1; mwe[0] = 1'b1; msel[0] = 4'hF; mdat[0] = 32'h0000_0011;
        mstb[1] = 1'b1; mwe[1] = 1'b1; msel[1] = 4'hF; mdat[1] = 32'h0000_0022;
        look(); chk("cont_t0_stb", 32'(s_stb_o), 32'd0);
        dc(); look(); chk("cont_t1_dat", s_dat_o, 32'h0000_0011);
        dc(); look(); chk("cont_t2_acks", 32'({m1_ack_o, m0_ack_o}), 32'd1);
        dc(); mstb[0] = 1'b0;
        look(); chk("cont_t3_stb", 32'(s_stb_o), 32'd0);
        dc(); look(); chk("cont_t4_stb", 32'(s_stb_o), 32'd1);
        chk("cont_t4_dat", s_dat_o, 32'h0000_0022);
        dc(); look(); chk("cont_t5_ack", 32'(m1_ack_o), 32'd1);
        dc(); mstb[1] = 1'b0;

        // Fairness with both masters requesting continuously.
        do_reset();
        mstb[0] = 1'b1; mwe[0] = 1'b0;
        mstb[1] = 1'b1; mwe[1] = 1'b0;
        n_acks = 0;
        for (int i = 0; i < 4; i++) order[i] = 9;
        for (int i = 0; i < 60 && n_acks < 4; i++) begin
            look();
            if (m0_ack_o) begin order[n_acks] = 0; n_acks++; end
            else if (m1_ack_o) begin order[n_acks] = 1; n_acks++; end
            dc();
        end
        mstb[0] = 1'b0; mstb[1] = 1'b0;
        chk("fair_count", 32'(n_acks), 32'd4);
        for (int i = 0; i < 4; i++) chk("fair_order", 32'(order[i]), 32'(i % 2));

        // Timeout on master 1 with a slave that never acks.
        slave_mode = 1;
        do_reset();
        mstb[1] = 1'b1; mwe[1] = 1'b0; msel[1] = 4'hF; mdat[1] = 32'h0B0B_0000;
        k = 99;
        ack_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            look();
            if (m1_ack_o) ack_seen = 1'b1;
            if (m1_err_o) begin k = i; break; end
            dc();
        end
        chk("timeout_cycle", 32'(k), 32'(T));
        chk("timeout_no_ack", 32'(ack_seen), 32'd0);
        dc(); mstb[1] = 1'b0;
        look(); chk("timeout_idle", 32'(s_stb_o), 32'd0);
        dc(); mstb[0] = 1'b1; mdat[0] = 32'hA0A0_0000; mstb[1] = 1'b1;
        look(); dc(); look();
        chk("timeout_prio", s_dat_o, 32'hA0A0_0000);
        dc(); mstb[0] = 1'b0; mstb[1] = 1'b0;
        dc();

        // Abort by master 0 leaves prio at 0.
        do_reset();
        mstb[0] = 1'b1; mdat[0] = 32'h0000_5A5A;
        look(); dc(); look(); chk("abort_t1_stb", 32'(s_stb_o), 32'd1);
        dc(); mstb[0] = 1'b0;
        look(); chk("abort_t2_ackerr", 32'({m0_err_o, m0_ack_o}), 32'd0);
        chk("abort_t2_stb", 32'(s_stb_o), 32'd0);
        dc(); mstb[0] = 1'b1; mstb[1] = 1'b1;
        look(); dc(); look();
        chk("abort_prio", s_dat_o, 32'h0000_5A5A);
        dc(); mstb[0] = 1'b0; mstb[1] = 1'b0;

        // Reset asserted during GRANT1.
        do_reset();
        mstb[1] = 1'b1; mwe[1] = 1'b1; msel[1] = 4'hF; mdat[1] = 32'hFFFF_FFFF;
        look(); dc(); look(); chk("rst_g1_stb", 32'(s_stb_o), 32'd1);
        dc(); wb_rst_i = 1'b1;
        look(); chk("rst_ctrl", 32'(dut_ctrl), 32'd0);
        chk("rst_dat", s_dat_o, 32'd0);
        dc(); wb_rst_i = 1'b0; mstb[0] = 1'b1; mdat[0] = 32'h1234_5678;
        look(); dc(); look();
        chk("rst_prio", s_dat_o, 32'h1234_5678);
        dc(); mstb[0] = 1'b0; mstb[1] = 1'b0;
        dc();

        // Randomized traffic across slave behaviours with sporadic resets.
        for (int blk = 0; blk < 6; blk++) begin
            slave_mode = $urandom_range(0, 2);
            repeat (500) begin
                dc();
                wb_rst_i = ($urandom % 150 == 0);
                rnd_ack  = ($urandom % 3 == 0);
                for (int m = 0; m < 2; m++) begin
                    if (mstb[m]) begin
                        if (mdone[m]) begin
                            mstb[m] = ($urandom % 3 == 0);
                            if (mstb[m]) new_req(m);
                        end else if ($urandom % 40 == 0) begin
                            mstb[m] = 1'b0;
                        end
                    end else if ($urandom % 3 == 0) begin
                        mstb[m] = 1'b1;
                        new_req(m);
                    end
                end
            end
        end
        wb_rst_i = 1'b0;
        mstb[0] = 1'b0; mstb[1] = 1'b0;
        dc();
        dc();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
